// File: rtl/counter_pkg.sv
// Shared types and arithmetic helpers for the parametrised up/down counter.
// The arithmetic helpers work one bit wider than the widest counter, so carries are never lost.
package counter_pkg;

    typedef enum logic {WRAP, SAT} count_mode_t;

    localparam int MAX_WIDTH   = 32;
    localparam int ARITH_GUARD = 1;
    localparam int ARITH_MAX_W = MAX_WIDTH + ARITH_GUARD;

    function automatic logic [ARITH_MAX_W-1:0] clamp_to_max(
        input logic [ARITH_MAX_W-1:0] v,
        input logic [ARITH_MAX_W-1:0] max
    );
        return (v > max) ? max : v;
    endfunction

    function automatic count_mode_t mode_from_sat(input bit sat);
        return sat ? SAT : WRAP;
    endfunction

endpackage

// File: rtl/counter_next_val.sv
// Combinational next-count datapath: adds or subtracts an already clamped step,
// then wraps modulo MAX+1 or saturates, and flags any crossing of the 0..MAX range.
module counter_next_val
    import counter_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}},
    parameter count_mode_t      MODE  = WRAP
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] s,
    input  logic             down,
    output logic [WIDTH-1:0] next,
    output logic             ovf_n,
    output logic             unf_n
);

    localparam int AW = WIDTH + ARITH_GUARD;

    logic [AW-1:0] c_x;
    logic [AW-1:0] s_x;
    logic [AW-1:0] max_x;
    logic [AW-1:0] mod_x;
    logic [AW-1:0] sum_x;
    logic [AW-1:0] res_x;

    assign c_x   = {1'b0, count};
    assign s_x   = {1'b0, s};
    assign max_x = {1'b0, MAX};
    assign mod_x = max_x + AW'(1);
    assign sum_x = c_x + s_x;

    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        res_x = sum_x;
        ovf_n = 1'b0;
        unf_n = 1'b0;
        if (!down) begin
            if (sum_x > max_x) begin
                ovf_n = 1'b1;
                res_x = (MODE == SAT) ? max_x : sum_x - mod_x;
            end
        end else begin
            res_x = c_x - s_x;
            if (s_x > c_x) begin
                unf_n = 1'b1;
                // Subtract first so the intermediate stays inside the range.
                res_x = (MODE == SAT) ? '0 : c_x + (mod_x - s_x);
            end
        end
        next = WIDTH'(res_x);
    end

endmodule

// File: rtl/updown_counter_mod.sv
// Up/down counter with a programmable terminal value, a variable step, a synchronous load and wrap or saturate behaviour.
// Holds the count/ovf/unf registers and applies the rst > load > en priority.
module updown_counter_mod
    import counter_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] MAX       = {WIDTH{1'b1}},
    parameter bit               SATURATE  = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             down,
    input  logic [WIDTH-1:0] step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             ovf,
    output logic             unf,
    output logic             at_max,
    output logic             at_min
);

    localparam count_mode_t MODE = mode_from_sat(SATURATE);

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] next;
    logic             ovf_n;
    logic             unf_n;

    assign s            = WIDTH'(clamp_to_max(ARITH_MAX_W'(step), ARITH_MAX_W'(MAX)));
    assign load_clamped = WIDTH'(clamp_to_max(ARITH_MAX_W'(load_val), ARITH_MAX_W'(MAX)));

    counter_next_val #(
        .WIDTH (WIDTH),
        .MAX   (MAX),
        .MODE  (MODE)
    ) u_next (
        .count (count),
        .s     (s),
        .down  (down),
        .next  (next),
        .ovf_n (ovf_n),
        .unf_n (unf_n)
    );

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= RESET_VAL;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (load) begin
            count <= load_clamped;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (en) begin
            count <= next;
            ovf   <= ovf_n;
            unf   <= unf_n;
        end else begin
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end
    end

    assign at_max = (count == MAX);
    assign at_min = (count == '0);

endmodule
